// File: rtl/mul_sequencer_pkg.sv
// Shared ALU control codes and multiplier sequencer state encoding.
package mul_sequencer_pkg;

  localparam logic [2:0] ALU_CODE_ADD = 3'b001;
  localparam logic [2:0] ALU_CODE_SUB = 3'b010;
  localparam logic [2:0] ALU_CODE_AND = 3'b011;
  localparam logic [2:0] ALU_CODE_OR  = 3'b100;
  localparam logic [2:0] ALU_CODE_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiplier datapath: operand registers, accumulator, adder and
// the result register that only updates on the final iteration.
module mul_shift_add_dp
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              last,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;

  // Conditional add of the shifted multiplicand, wrapping at DATA_W bits.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  // Operand latch on start, one iteration per step, result capture on the
  // last iteration so it is already valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
      end else if (step) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (last) begin
        result <= acc_next;
      end
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: FSM, iteration counter and pipeline
// stall/done handshake around the shift-add datapath.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter logic [2:0]  ALU_MUL = ALU_CODE_MUL
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int unsigned     CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  mul_state_t       state;
  logic [CNT_W-1:0] count;
  logic             done_q;
  logic             start;
  logic             step;
  logic             last;

  // Handshake decode: start only from IDLE, a flush squashes the iteration.
  always_comb begin
    start   = (state == IDLE) && valid_i && (ALUCtrl_i == ALU_MUL) && !flush_i;
    step    = (state == BUSY) && !flush_i;
    last    = step && (count == CNT_LAST);
    // Gated by reset so the stall drops the moment reset asserts.
    stall_o = rst_i && (start || step);
  end

  // Sequencer FSM with the iteration counter and registered done pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            count <= '0;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (count == CNT_LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign done_o = done_q;

  mul_shift_add_dp #(
    .DATA_W(DATA_W)
  ) u_dp (
    .clk   (clk_i),
    .rst_n (rst_i),
    .load  (start),
    .step  (step),
    .last  (last),
    .op_a  (data1_i),
    .op_b  (data2_i),
    .result(result_o)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: cycle-level reference model built
// from the multiply latency rules plus directed literal scenarios.
module tb_mul_sequencer;

  localparam int unsigned DW  = 32;
  localparam logic [2:0]  MUL = 3'b110;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [2:0]    ALUCtrl_i;
  logic          flush_i;
  logic [DW-1:0] data1_i;
  logic [DW-1:0] data2_i;
  logic          stall_o;
  logic          done_o;
  logic [DW-1:0] result_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mul_sequencer #(
    .DATA_W (DW),
    .ALU_MUL(MUL)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ALUCtrl_i(ALUCtrl_i),
    .flush_i  (flush_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Reference model: k = cycles elapsed since the accepted start (-1 = none).
  // Cycles 1..DW are the iterations, cycle DW+1 is the done cycle.
  int          k    = -1;
  logic [DW-1:0] pend = '0;
  logic [DW-1:0] mres = '0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      k    <= -1;
      mres <= '0;
    end else if (k < 0) begin
      if (valid_i && ALUCtrl_i == MUL && !flush_i) begin
        k    <= 1;
        pend <= data1_i * data2_i;
      end
    end else if (k <= int'(DW)) begin
      if (flush_i) begin
        k <= -1;
      end else begin
        k <= k + 1;
        if (k == int'(DW)) mres <= pend;
      end
    end else begin
      k <= -1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk_i) begin
    logic exp_stall;
    logic exp_done;
    exp_stall = rst_i && ((k < 0 && valid_i && ALUCtrl_i == MUL && !flush_i) ||
                          (k >= 1 && k <= int'(DW) && !flush_i));
    exp_done  = rst_i && (k == int'(DW) + 1);
    check("model_stall", 64'(stall_o), 64'(exp_stall));
    check("model_done", 64'(done_o), 64'(exp_done));
    check("model_result", 64'(result_o), 64'(mres));
  end

  // Issue one MUL and hold it in EX until done; reports stall count,
  // start-to-done latency and the result seen in the done cycle.
  task automatic mul_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int stalls, output int lat, output int done_at,
                        output logic [DW-1:0] res);
    int start_at;
    valid_i   = 1'b1;
    ALUCtrl_i = MUL;
    flush_i   = 1'b0;
    data1_i   = a;
    data2_i   = b;
    stalls    = 0;
    lat       = -1;
    done_at   = -1;
    start_at  = -1;
    res       = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (start_at < 0) start_at = cyc;
      if (stall_o) stalls++;
      if (done_o) begin
        done_at = cyc;
        lat     = cyc - start_at;
        res     = result_o;
      end
      @(posedge clk_i);
      #1;
      if (done_at >= 0) break;
    end
    if (done_at < 0) check("mul_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int            stalls;
    int            lat;
    int            d1;
    int            d2;
    int            seen;
    logic [DW-1:0] res;

    rst_i     = 1'b0;
    valid_i   = 1'b0;
    ALUCtrl_i = 3'b000;
    flush_i   = 1'b0;
    data1_i   = '0;
    data2_i   = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_stall", 64'(stall_o), 64'(0));
    check("reset_done", 64'(done_o), 64'(0));
    check("reset_result", 64'(result_o), 64'(0));
    rst_i = 1'b1;

    // 6 x 7
    mul_op(32'd6, 32'd7, stalls, lat, d1, res);
    check("6x7_stalls", 64'(stalls), 64'(33));
    check("6x7_latency", 64'(lat), 64'(33));
    check("6x7_result", 64'(res), 64'(42));
    valid_i = 1'b0;
    @(posedge clk_i); #1;

    // all-ones squared wraps to 1
    mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls, lat, d1, res);
    check("ones_latency", 64'(lat), 64'(33));
    check("ones_result", 64'(res), 64'(1));
    valid_i = 1'b0;
    @(posedge clk_i); #1;

    // back-to-back
    mul_op(32'd3, 32'd5, stalls, lat, d1, res);
    check("b2b_first", 64'(res), 64'(15));
    mul_op(32'h0001_0000, 32'h0001_0000, stalls, lat, d2, res);
    check("b2b_second", 64'(res), 64'(0));
    check("b2b_spacing", 64'(d2 - d1), 64'(34));

    // zero operand keeps the full latency
    mul_op(32'd0, 32'd123, stalls, lat, d1, res);
    check("zero_latency", 64'(lat), 64'(33));
    check("zero_result", 64'(res), 64'(0));

    // non-MUL instructions never stall
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      valid_i   = 1'b1;
      ALUCtrl_i = (n % 2 == 0) ? 3'b001 : 3'b010;
      data1_i   = $urandom;
      data2_i   = $urandom;
      @(negedge clk_i);
      if (stall_o || done_o) seen++;
      @(posedge clk_i); #1;
    end
    check("nonmul_quiet", 64'(seen), 64'(0));
    valid_i = 1'b0;

    // reference value for the flush test
    mul_op(32'd10, 32'd10, stalls, lat, d1, res);
    check("10x10_result", 64'(res), 64'(100));
    valid_i = 1'b0;
    @(posedge clk_i); #1;

    // flush on iteration 10
    valid_i   = 1'b1;
    ALUCtrl_i = MUL;
    data1_i   = 32'd9;
    data2_i   = 32'd9;
    repeat (10) begin
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_stall", 64'(stall_o), 64'(0));
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    seen    = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (done_o) seen++;
    end
    check("flush_no_done", 64'(seen), 64'(0));
    check("flush_result_kept", 64'(result_o), 64'(100));
    @(posedge clk_i); #1;

    // asynchronous reset on iteration 5
    valid_i = 1'b1;
    data1_i = 32'd7;
    data2_i = 32'd7;
    repeat (5) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
    #1;
    check("rst_mid_stall", 64'(stall_o), 64'(0));
    check("rst_mid_result", 64'(result_o), 64'(0));
    check("rst_mid_done", 64'(done_o), 64'(0));
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    mul_op(32'd2, 32'd2, stalls, lat, d1, res);
    check("post_rst_result", 64'(res), 64'(4));
    check("post_rst_latency", 64'(lat), 64'(33));

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 1500; n++) begin
      valid_i   = ($urandom_range(0, 3) != 0);
      ALUCtrl_i = ($urandom_range(0, 1) != 0) ? MUL : 3'($urandom_range(0, 7));
      flush_i   = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 5))
        0:       data1_i = '0;
        1:       data1_i = '1;
        default: data1_i = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       data2_i = '0;
        1:       data2_i = '1;
        default: data2_i = $urandom;
      endcase
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    flush_i = 1'b0;
    repeat (40) @(posedge clk_i);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
